regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 111 +++++++++++
 tb/tb_regfile_dump.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Walks a register-file read port from start_addr to end_addr (with wrap-around)
// and presents each captured register as a valid/ready stream element.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  logic              w_accept;
  logic              w_hs;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_cur_inc;

  assign w_accept  = (r_state == IDLE) && start && !abort;
  assign w_hs      = (r_state == SEND) && out_ready && !abort;
  assign w_is_last = (r_cur == r_last);
  assign w_cur_inc = r_cur + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = LOAD;
      LOAD: w_next = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_hs) begin
          w_next = w_is_last ? DONE : LOAD;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address walk and element capture; abort discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur      <= '0;
      r_last     <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cur  <= start_addr;
            r_last <= end_addr;
          end
        end
        LOAD: begin
          if (!abort) begin
            r_out_data <= rd_data;
            r_out_addr <= r_cur;
          end
        end
        SEND: begin
          if (w_hs && !w_is_last) begin
            r_cur <= w_cur_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // rd_addr follows cur in every state so it stays stable while stalled.
  assign rd_addr   = r_cur;
  assign out_valid = (r_state == SEND);
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a behavioural register file feeds rd_data and
// each scenario task compares the observed stream against hand-derived values.
module tb_regfile_dump;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [32];

  int checks;
  int errors;

  logic [ADDR_W-1:0] got_addr[$];
  logic [DATA_W-1:0] got_data[$];
  int done_cnt;
  int done_cyc;
  int first_hs;
  int last_hs;
  bit timeout;

  regfile_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] reg_val(input int i);
    if (i == 0) return 32'h0000_0000;
    if (i == 5) return 32'hDEAD_BEEF;
    return 32'h1111_0000 + i;
  endfunction

  // Inputs change and outputs are observed on the falling edge.
  task automatic pulse_start(input int s, input int e);
    start      = 1'b1;
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records accepted elements with out_ready held high; optionally fires a
  // second start (9..12) at cycle inject_at while the dump is running.
  task automatic collect(input int max_cyc, input int inject_at);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_hs = -1;
    last_hs  = -1;
    timeout  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      if (c == inject_at) begin
        start      = 1'b1;
        start_addr = 5'd9;
        end_addr   = 5'd12;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, done, busy} !== 3'b000 || rd_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%0b b=%0b rd=%0h oa=%0h od=%0h required all 0",
               out_valid, done, busy, rd_addr, out_addr, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_full_dump();
    bit ok;
    pulse_start(0, 31);
    collect(200, -1);
    checks++;
    if (timeout || got_addr.size() != 32) begin
      errors++;
      $display("FAIL full_count: got %0d elements (timeout=%0b) required 32", got_addr.size(), timeout);
    end
    ok = 1'b1;
    foreach (got_addr[i]) begin
      if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== reg_val(i)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_order: element sequence differs from 0..31 with register contents");
    end
    checks++;
    if (got_addr.size() < 6 || got_addr[5] !== 5'd5 || got_data[5] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL full_elem5: got %0h/%0h required 5/deadbeef",
               (got_addr.size() > 5) ? got_addr[5] : 5'h1f, (got_data.size() > 5) ? got_data[5] : 32'h0);
    end
    checks++;
    if (first_hs != 0) begin
      errors++;
      $display("FAIL full_latency: first element at cycle %0d required 0 (2 cycles after start)", first_hs);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL full_done: got %0d pulses at cycle %0d required 1 pulse at cycle %0d",
               done_cnt, done_cyc, last_hs + 1);
    end
    checks++;
    if (last_hs != 62) begin
      errors++;
      $display("FAIL full_throughput: last element at cycle %0d required 62", last_hs);
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    bit ok;
    exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
    pulse_start(30, 1);
    collect(40, -1);
    ok = (got_addr.size() == 4) && !timeout;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        if (got_addr[i] !== exp_a[i] || got_data[i] !== reg_val(int'(exp_a[i]))) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wrap_seq: got %0d elements required 30,31,0,1", got_addr.size());
    end
    checks++;
    if (got_data.size() < 3 || got_data[2] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_elem0: got %0h required 0", (got_data.size() > 2) ? got_data[2] : 32'hffff_ffff);
    end
  endtask

  task automatic test_single();
    pulse_start(7, 7);
    collect(20, -1);
    checks++;
    if (timeout || got_addr.size() != 1 || got_addr[0] !== 5'd7 || got_data[0] !== reg_val(7) || done_cnt != 1) begin
      errors++;
      $display("FAIL single_elem: got %0d elements, %0d done pulses required 1 element (7) and 1 pulse",
               got_addr.size(), done_cnt);
    end
  endtask

  task automatic test_stall();
    int stall;
    bit held_ok;
    bit ok;
    bit fin;
    stall   = 0;
    held_ok = 1'b1;
    fin     = 1'b0;
    got_addr.delete();
    got_data.delete();
    pulse_start(0, 5);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == 5'd3 && stall < 5) begin
        out_ready = 1'b0;
        if (out_data !== reg_val(3) || rd_addr !== 5'd3) held_ok = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
      end
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (stall != 5 || !held_ok) begin
      errors++;
      $display("FAIL stall_hold: stalled %0d cycles held_ok=%0b required 5 and 1", stall, held_ok);
    end
    ok = fin && (got_addr.size() == 6);
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== reg_val(i)) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_seq: got %0d elements required 0..5 once each", got_addr.size());
    end
  endtask

  task automatic test_abort();
    bit found;
    int extra;
    found = 1'b0;
    extra = 0;
    out_ready = 1'b1;
    pulse_start(0, 7);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == 5'd2) begin
        found = 1'b1;
        abort = 1'b1;
        break;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!found || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: found=%0b busy=%0b valid=%0b done=%0b required 1,0,0,0",
               found, busy, out_valid, done);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after abort required 0", extra);
    end
  endtask

  task automatic test_start_abort_idle();
    start      = 1'b1;
    abort      = 1'b1;
    start_addr = 5'd3;
    end_addr   = 5'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    pulse_start(0, 7);
    collect(60, 3);
    ok = !timeout && (got_addr.size() == 8) && (done_cnt == 1);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== reg_val(i)) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_while_busy: got %0d elements, %0d done required 0..7 and 1 done",
               got_addr.size(), done_cnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy_idle: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start(4, 7);
    checks++;
    if (rd_addr !== 5'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_rd_addr: rd=%0h busy=%0b required 4 and 1", rd_addr, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, done, busy} !== 3'b000 || rd_addr !== '0 || out_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%0b d=%0b b=%0b rd=%0h oa=%0h od=%0h required all 0",
               out_valid, done, busy, rd_addr, out_addr, out_data);
    end
    @(negedge clk);
    pulse_start(10, 12);
    collect(30, -1);
    ok = !timeout && (got_addr.size() == 3) && (done_cnt == 1);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        if (got_addr[i] !== ADDR_W'(10 + i) || got_data[i] !== reg_val(10 + i)) ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_restart: got %0d elements required 10..12", got_addr.size());
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = reg_val(i);
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_wrap();
    test_single();
    test_stall();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
